// File: rtl/sync_fifo_param_pkg.sv
// Shared configuration for the parametrised FIFO: default geometry and thresholds.
// The macros may be predefined by the build to retarget every instance at once.
`ifndef D_LENGTH
`define D_LENGTH 8
`endif
`ifndef A_LENGTH
`define A_LENGTH 3
`endif
`ifndef CONFIG_DEPTH
`define CONFIG_DEPTH (1 << `A_LENGTH)
`endif
`ifndef AF_THRESH
`define AF_THRESH 6
`endif
`ifndef AE_THRESH
`define AE_THRESH 2
`endif

package sync_fifo_param_pkg;

    localparam int DEF_D_LENGTH  = `D_LENGTH;
    localparam int DEF_A_LENGTH  = `A_LENGTH;
    localparam int DEF_DEPTH     = `CONFIG_DEPTH;
    localparam int DEF_AF_THRESH = `AF_THRESH;
    localparam int DEF_AE_THRESH = `AE_THRESH;

    function automatic int depth_of(input int a_len);
        return 1 << a_len;
    endfunction

endpackage

// File: rtl/sync_fifo_param_dpsram.sv
// Dual-port RAM: synchronous write on port A, registered read on port B, one clock.
// Contents are never reset; only the port-B output register clears on rst.
module dpsram_param #(
    parameter int D_LENGTH = 8,
    parameter int A_LENGTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_en,
    input  logic [A_LENGTH-1:0] a_addr,
    input  logic [D_LENGTH-1:0] a_data,
    input  logic                b_en,
    input  logic [A_LENGTH-1:0] b_addr,
    output logic [D_LENGTH-1:0] b_data
);

    logic [D_LENGTH-1:0] mem [2**A_LENGTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            mem[a_addr] <= a_data;
        end
    end

    // Output register holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_data <= '0;
        end else if (b_en) begin
            b_data <= mem[b_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO over dpsram_param: pointers, occupancy, threshold flags, sticky errors.
// Read data and rd_valid appear 1 clock after an accepted rd_en; writes when full are dropped.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int D_LENGTH  = DEF_D_LENGTH,
    parameter int A_LENGTH  = DEF_A_LENGTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [D_LENGTH-1:0] wr_data,
    input  logic                rd_en,
    input  logic                clr_err,
    output logic [D_LENGTH-1:0] rd_data,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [A_LENGTH:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = depth_of(A_LENGTH);
    localparam logic [A_LENGTH:0] DEPTH_W = DEPTH[A_LENGTH:0];
    localparam logic [A_LENGTH:0] AF_W    = AF_THRESH[A_LENGTH:0];
    localparam logic [A_LENGTH:0] AE_W    = AE_THRESH[A_LENGTH:0];

    logic [A_LENGTH:0] wr_ptr;
    logic [A_LENGTH:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Accept decisions use the registered flags, so a full FIFO rejects a
    // write even when a read in the same cycle frees a slot.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign full         = (count == DEPTH_W);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_W);
    assign almost_empty = (count <= AE_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    dpsram_param #(
        .D_LENGTH (D_LENGTH),
        .A_LENGTH (A_LENGTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .a_en   (wr_acc),
        .a_addr (wr_ptr[A_LENGTH-1:0]),
        .a_data (wr_data),
        .b_en   (rd_acc),
        .b_addr (rd_ptr[A_LENGTH-1:0]),
        .b_data (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;
    logic          m_ovf;
    logic          m_unf;
    int            m_wptr;
    int            m_rptr;

    sync_fifo_param #(
        .D_LENGTH  (DW),
        .A_LENGTH  (AW),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        m_wptr     = 0;
        m_rptr     = 0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".rvld"}, 32'(rd_valid), 32'(m_rd_valid));
        chk({tag, ".rdata"}, 32'(rd_data), 32'(m_rd_data));
    endtask

    // One clock with the given inputs; the model applies the FIFO rules to the pre-edge occupancy.
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic c);
        logic was_full;
        logic was_empty;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (w && was_full) m_ovf = 1'b1;
        else if (c)        m_ovf = 1'b0;
        if (r && was_empty) m_unf = 1'b1;
        else if (c)         m_unf = 1'b0;
        m_rd_valid = r && !was_empty;
        if (r && !was_empty) begin
            m_rd_data = q.pop_front();
            m_rptr = (m_rptr + 1) % (2 * DEPTH);
        end
        if (w && !was_full) begin
            q.push_back(d);
            m_wptr = (m_wptr + 1) % (2 * DEPTH);
        end
        #1;
        check_all(tag);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Fill 0x01..0x08
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        // Extra write while full: rejected, head entry must be untouched
        step("ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf.head", 32'(dut.u_ram.mem[dut.rd_ptr[AW-1:0]]), 32'(q[0]));
        step("clr", 1'b0, 8'h00, 1'b0, 1'b1);
        // Full with simultaneous read+write
        step("full.rw", 1'b1, 8'h55, 1'b1, 1'b0);
        step("clr2", 1'b0, 8'h00, 1'b0, 1'b1);
        // Drain
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        // Empty with simultaneous read+write, and clr_err colliding with a new underflow
        step("empty.rw", 1'b1, 8'h66, 1'b1, 1'b0);
        step("rd1", 1'b0, 8'h00, 1'b1, 1'b0);
        step("unf.clr", 1'b0, 8'h00, 1'b1, 1'b1);

        // Wrap-around from a fresh reset
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) step("wrap.w", 1'b1, 8'(8'h10 + 5 * k + i), 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) step("wrap.r", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wrap.wptr", 32'(dut.wr_ptr), 32'(m_wptr));
        chk("wrap.rptr", 32'(dut.rd_ptr), 32'(m_rptr));
        chk("wrap.ptr15", 32'(m_wptr), 32'd15);

        // Simultaneous access at count 4
        for (int i = 0; i < 4; i++) step("sim.fill", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("sim.rw", 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        step("sim.w", 1'b1, 8'h50, 1'b0, 1'b0);

        // Asynchronous reset between edges at count 5
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("midrst");
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("post.w", 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("post.addr0", 32'(dut.u_ram.mem[0]), 32'h0AA);
        step("post.r", 1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic with shifting read/write bias
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                int pw;
                int pr;
                pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
                pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
                step("rand",
                     1'($urandom_range(99) < pw),
                     8'($urandom),
                     1'($urandom_range(99) < pr),
                     1'($urandom_range(99) < 5));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO built around a parametrised dual-port RAM core.
- Port A is write-only and port B is read-only, both on one clock.
- Adds the following, none of which the raw dual-port RAM provides:
  - pointer management
  - full/empty and almost-full/almost-empty flags
  - occupancy count
  - sticky overflow/underflow error flags
  - a read-valid strobe
- Sits between producer and consumer datapaths in the FIFO top levels.

Parameters:
- D_LENGTH, 8, data word width in bits.
- A_LENGTH, 3, address width; depth is fixed at DEPTH = 2**A_LENGTH (power of two only).
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  D_LENGTH  write data.
- rd_en  input  1  read request.
- clr_err  input  1  synchronous clear of overflow/underflow.
- rd_data  output  D_LENGTH  registered read data.
- rd_valid  output  1  rd_data updated this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  A_LENGTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset state (immediate on rst rise):
  - wr_ptr = rd_ptr = 0, count = 0, rd_data = 0, rd_valid = 0.
  - overflow = underflow = 0.
  - Flags: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - RAM contents are not reset.
- Accept rules, evaluated against the registered state at the clock edge:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
- Write: on wr_acc, mem[wr_ptr[A_LENGTH-1:0]] <= wr_data and wr_ptr increments.
- Read: on rd_acc, rd_data <= mem[rd_ptr[A_LENGTH-1:0]], rd_ptr increments, and rd_valid = 1 on the following cycle only.
  - Latency is 1 clock from rd_en sample to rd_data/rd_valid.
  - rd_data holds its last value when there is no accepted read.
- Pointers are A_LENGTH+1 bits and wrap naturally modulo 2*DEPTH; the RAM index uses the low A_LENGTH bits.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged on both or neither.
- Flags are combinational decodes of the registered count (glitch-free, no extra latency).
- Simultaneous read and write:
  - Both accepted when 0 < count < DEPTH; count is unchanged.
  - When full: the read is accepted and the write is rejected (full is sampled before the read frees a slot); count goes to DEPTH-1 and overflow is set.
  - When empty: the write is accepted and the read is rejected (no fall-through); count goes to 1 and underflow is set.
- Error flags:
  - overflow <= 1 on wr_en & full.
  - underflow <= 1 on rd_en & empty.
  - clr_err clears both; a new set event in the same cycle wins over clr_err.
- Rejected accesses modify neither pointers nor RAM.
- Reset mid-operation: all state returns to the reset values asynchronously. The first accepted write after rst deasserts lands at address 0. A read in flight is discarded (rd_valid = 0).
- No state machine beyond the pointer/count registers. Full and empty are mutually exclusive by construction.

Decomposition:
- Shared include para.h defines the default macros `d_length, `a_length, `config_depth, `af_thresh and `ae_thresh. These feed the parameter defaults.
- Sub-module dpsram_param (parameters D_LENGTH, A_LENGTH):
  - Synchronous write on port A and registered read on port B.
  - Per-port enables, same clock.
  - It is the parametrised generalisation of the existing dual-port RAM.
- The FIFO top holds pointers, count, flags, error logic and rd_valid.

Test Plan (defaults: DEPTH 8, D_LENGTH 8, AF 6, AE 2):
- Reset, then fill: write 0x01..0x08 on consecutive cycles.
  - count steps 1..8.
  - almost_empty drops when count = 3.
  - almost_full rises at count = 6.
  - full = 1 after the 8th write; overflow stays 0.
- Drain after fill: rd_en for 8 cycles.
  - rd_data = 0x01..0x08, each one cycle after its rd_en, with rd_valid high for 8 cycles.
  - empty = 1 and count = 0 at the end.
- Wrap-around: do 5 writes then 5 reads, three times, with data 0x10+i.
  - Data order is preserved across the pointer wrap.
  - wr_ptr = rd_ptr = 15 (mod 16) at the end; count = 0.
- Simultaneous access:
  - At count = 4, wr_en & rd_en for 3 cycles → count stays 4 and the data order is correct.
  - When full, wr_en & rd_en → count = 7 and overflow = 1.
  - When empty, wr_en & rd_en → count = 1, underflow = 1, rd_valid = 0.
- Errors and clear:
  - wr_en with full → overflow = 1 and the RAM entry at the head is unchanged.
  - clr_err alone → overflow = 0.
  - clr_err together with rd_en when empty → underflow = 1.
- Mid-operation reset: at count = 5, assert rst asynchronously between edges.
  - Flags and count return to the reset values immediately.
  - After deassert, write 0xAA then read → rd_data = 0xAA.
